shift_arbiter: RTL and testbench

Shares one combinational 16-bit right shifter between two requesters (port 0, port 1) using valid/ready handshakes. Arbitration is round-robin. The block captures the shifter result into a register and returns it on the granted port's response channel. It allows one outstanding operation and supports back-to-back issue when the response drains in the same cycle. It sits between the execute-stage consumers (e.g. ALU shift path, address/immediate unit) and the single shifter instance.

---
 rtl/shift_arbiter_pkg.sv | 8 +
 rtl/shift_arbiter_shift_right.sv | 13 +
 rtl/shift_arbiter.sv | 71 +++++++
 tb/tb_shift_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/shift_arbiter_pkg.sv
// shift_arbiter_pkg: shared encodings and widths for the shift arbiter slice
package shift_arbiter_pkg;
  localparam int N_DEF = 16;
  localparam int C_DEF = 4;
  localparam logic OP_ARITH = 1'b0;
  localparam logic OP_LOGIC = 1'b1;
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;
endpackage

// File: rtl/shift_arbiter_shift_right.sv
// shift_right: 16-bit combinational right shifter, zero or sign fill
module shift_right
  import shift_arbiter_pkg::*;
(
  input  logic [15:0] in_i,
  input  logic [3:0]  cnt_i,
  input  logic        op_i,
  output logic [15:0] out_o
);
  logic [16:0] ext;
  assign ext = $signed({(op_i == OP_ARITH) & in_i[15], in_i}) >>> cnt_i;
  assign out_o = ext[15:0];
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of one shifter between two valid/ready ports
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int C = C_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_in,
  input  logic [C-1:0] req0_cnt,
  input  logic         req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_in,
  input  logic [C-1:0] req1_cnt,
  input  logic         req1_op,
  output logic         resp0_valid,
  input  logic         resp0_ready,
  output logic [N-1:0] resp0_data,
  output logic         resp1_valid,
  input  logic         resp1_ready,
  output logic [N-1:0] resp1_data
);
  state_e state_q, state_d;
  logic rr_q, rr_d, owner_q, owner_d;
  logic [N-1:0] result_q, result_d, sh_out;
  logic grant, resp_done, can_issue, acc;
  assign resp_done = (state_q == RESP) && (owner_q ? resp1_ready : resp0_ready);
  assign can_issue = (state_q == IDLE) || resp_done;
  assign grant = (req0_valid && req1_valid) ? rr_q : req1_valid;
  assign acc = can_issue && (req0_valid || req1_valid) && !rst;
  shift_right u_shift (
    .in_i  (grant ? req1_in  : req0_in),
    .cnt_i (grant ? req1_cnt : req0_cnt),
    .op_i  (grant ? req1_op  : req0_op),
    .out_o (sh_out)
  );
  // state and datapath registers, synchronous reset discards any pending result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      owner_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      result_q <= result_d;
    end
  end
  // next state: a new accept always lands in RESP, a drained response alone returns to IDLE
  always_comb begin
    state_d  = acc ? RESP : (resp_done ? IDLE : state_q);
    owner_d  = acc ? grant : owner_q;
    rr_d     = acc ? ~grant : rr_q;
    result_d = acc ? sh_out : result_q;
  end
  // outputs: readiness follows the grant, response valid follows the owner
  always_comb begin
    req0_ready  = acc && !grant;
    req1_ready  = acc && grant;
    resp0_valid = (state_q == RESP) && !owner_q;
    resp1_valid = (state_q == RESP) && owner_q;
  end
  assign resp0_data = result_q;
  assign resp1_data = result_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: scoreboard bench with random traffic and a behavioural shift/arbitration model
module tb_shift_arbiter;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, req0_op = 0, req1_op = 0;
  logic [15:0] req0_in = 0, req1_in = 0;
  logic [3:0] req0_cnt = 0, req1_cnt = 0;
  logic req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic resp0_ready = 0, resp1_ready = 0;
  logic [15:0] resp0_data, resp1_data;
  typedef struct {bit port; logic [15:0] data; int cyc;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit last = 1;
  shift_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in(req0_in), .req0_cnt(req0_cnt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in(req1_in), .req1_cnt(req1_cnt), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input int n, input bit lg);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = (i + n < 16) ? d[i + n] : (lg ? 1'b0 : d[15]);
    return r;
  endfunction
  task automatic step(input bit r, input bit v0, input logic [15:0] i0, input logic [3:0] c0, input bit o0,
                      input bit v1, input logic [15:0] i1, input logic [3:0] c1, input bit o1,
                      input bit a0, input bit a1);
    bit can, g;
    bit [1:0] er;
    exp_t e;
    @(negedge clk);
    rst = r; req0_valid = v0; req0_in = i0; req0_cnt = c0; req0_op = o0;
    req1_valid = v1; req1_in = i1; req1_cnt = c1; req1_op = o1;
    resp0_ready = a0; resp1_ready = a1;
    #2;
    can = !r && (q.size() == 0 || (q[0].port ? a1 : a0));
    g = (v0 && v1) ? !last : v1;
    er = {can && v1 && g, can && v0 && !g};
    n_cmp++;
    if ({req1_ready, req0_ready} !== er) begin
      n_bad++;
      $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, {req1_ready, req0_ready}, er);
    end
    if (r) begin
      q.delete();
      last = 1;
    end else if (er != 0) begin
      e.port = g;
      e.data = g ? ref_shift(i1, int'(c1), o1) : ref_shift(i0, int'(c0), o0);
      e.cyc = cyc;
      q.push_back(e);
      last = g;
    end
  endtask
  initial forever begin
    bit hv, e0, e1;
    logic [15:0] got;
    @(negedge clk);
    #3;
    if (!rst) begin
      hv = q.size() > 0 && q[0].cyc < cyc;
      e0 = 0;
      e1 = 0;
      if (hv) begin
        e0 = !q[0].port;
        e1 = q[0].port;
      end
      n_cmp++;
      if ({resp1_valid, resp0_valid} !== {e1, e0}) begin
        n_bad++;
        $display("FAIL resp_valid cyc=%0d got=%b exp=%b", cyc, {resp1_valid, resp0_valid}, {e1, e0});
      end
      if (hv) begin
        got = q[0].port ? resp1_data : resp0_data;
        n_cmp++;
        if (got !== q[0].data) begin
          n_bad++;
          $display("FAIL resp%0d_data cyc=%0d got=%h exp=%h", q[0].port, cyc, got, q[0].data);
        end
        if (q[0].port ? resp1_ready : resp0_ready) void'(q.pop_front());
      end
    end
  end
  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 1, 16'h8000, 4, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 16'h8000, 4, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1, 16'h8001, 15, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 16'h1234, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++)
      step(0, 1, 16'hF00F + 16'(i), 4'(i), i[0], 1, 16'h8421 ^ 16'(i << 3), 4'(15 - i), ~i[0], 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 1, 16'hA5A5, 3, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 16'h9000, 2, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 16'h9000, 2, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 1, 16'hC3C3, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 16'h7FFF, 5, 0, 1, 16'hFFFF, 6, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, 16'($urandom), 4'($urandom), 1'($urandom),
           $urandom_range(0, 2) != 0, 16'($urandom), 4'($urandom), 1'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
